// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - I/D port arbiter in front of sdram_controller
//
// Serialises one block transaction at a time from a read-only instruction port
// (I) and a read/write data port (D) onto the controller's request interface.
// Optional build macro: ARB_ROUND_ROBIN_EN (alternate I/D on simultaneous
// requests; otherwise D always wins).
//
// Ports:
//   iclk, ireset                 clock, synchronous active-high reset
//   ii_req/ii_address            I-port read request, held until oi_ack
//   oi_data/oi_ack               I-port read data (valid with ack), ack pulse
//   id_req/id_we/id_address/id_wdata  D-port request, held until od_ack
//   od_rdata/od_ack              D-port read data (valid with ack), ack pulse
//   imem_ready                   controller idle
//   owrite_req/address/data      write request to controller
//   iwrite_ack                   controller write-done pulse
//   oread_req/address            read request to controller
//   iread_data/iread_ack         controller read data and read-done pulse
module sdram_port_arbiter #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 22
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              ii_req,
  input  logic [ADDR_W-1:0] ii_address,
  output logic [DATA_W-1:0] oi_data,
  output logic              oi_ack,
  input  logic              id_req,
  input  logic              id_we,
  input  logic [ADDR_W-1:0] id_address,
  input  logic [DATA_W-1:0] id_wdata,
  output logic [DATA_W-1:0] od_rdata,
  output logic              od_ack,
  input  logic              imem_ready,
  output logic              owrite_req,
  output logic [ADDR_W-1:0] owrite_address,
  output logic [DATA_W-1:0] owrite_data,
  input  logic              iwrite_ack,
  output logic              oread_req,
  output logic [ADDR_W-1:0] oread_address,
  input  logic [DATA_W-1:0] iread_data,
  input  logic              iread_ack
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_grant_d;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_i_data;
  logic [DATA_W-1:0] r_d_data;
  logic              w_grant_d;
  logic              w_accept;
  logic              w_done;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = D was served last. Reset to "I served last" so D wins the first tie.
  logic r_last_d;

  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_last_d <= 1'b0;
    end else if (r_state == S_RESP) begin
      r_last_d <= r_grant_d;
    end
  end

  assign w_grant_d = id_req & (~ii_req | ~r_last_d);
`else
  assign w_grant_d = id_req;
`endif

  assign w_accept = (ii_req | id_req) & imem_ready;
  // Only the ack matching the issued direction completes the transfer.
  assign w_done   = r_we ? iwrite_ack : iread_ack;

  // State register
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ISSUE;
      // Leave as soon as the controller drops ready, so the req is already low
      // by the time the controller can return to idle.
      S_ISSUE: if (!imem_ready) w_next = S_WAIT;
      // imem_ready is ignored here: the controller may raise it mid-read.
      S_WAIT:  if (w_done) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic (functions of registered state only)
  always_comb begin
    owrite_req = 1'b0;
    oread_req  = 1'b0;
    oi_ack     = 1'b0;
    od_ack     = 1'b0;
    if (r_state == S_ISSUE) begin
      owrite_req = r_we;
      oread_req  = ~r_we;
    end
    if (r_state == S_RESP) begin
      oi_ack = ~r_grant_d;
      od_ack = r_grant_d;
    end
  end

  // Request latch and read-data capture
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_grant_d <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_data  <= '0;
      r_d_data  <= '0;
    end else begin
      if (r_state == S_IDLE && w_accept) begin
        r_grant_d <= w_grant_d;
        r_we      <= w_grant_d & id_we;
        r_addr    <= w_grant_d ? id_address : ii_address;
        if (w_grant_d && id_we) begin
          r_wdata <= id_wdata;
        end
      end
      if (r_state == S_WAIT && !r_we && iread_ack) begin
        if (r_grant_d) begin
          r_d_data <= iread_data;
        end else begin
          r_i_data <= iread_data;
        end
      end
    end
  end

  assign owrite_address = r_addr;
  assign oread_address  = r_addr;
  assign owrite_data    = r_wdata;
  assign oi_data        = r_i_data;
  assign od_rdata       = r_d_data;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;

  logic         iclk = 1'b0;
  logic         ireset = 1'b1;
  logic         ii_req = 1'b0;
  logic [21:0]  ii_address = '0;
  logic [127:0] oi_data;
  logic         oi_ack;
  logic         id_req = 1'b0;
  logic         id_we = 1'b0;
  logic [21:0]  id_address = '0;
  logic [127:0] id_wdata = '0;
  logic [127:0] od_rdata;
  logic         od_ack;
  logic         imem_ready;
  logic         owrite_req;
  logic [21:0]  owrite_address;
  logic [127:0] owrite_data;
  logic         iwrite_ack;
  logic         oread_req;
  logic [21:0]  oread_address;
  logic [127:0] iread_data;
  logic         iread_ack;

  always #5 iclk = ~iclk;

  sdram_port_arbiter #(.DATA_W(128), .ADDR_W(22)) dut (
    .iclk(iclk), .ireset(ireset),
    .ii_req(ii_req), .ii_address(ii_address), .oi_data(oi_data), .oi_ack(oi_ack),
    .id_req(id_req), .id_we(id_we), .id_address(id_address), .id_wdata(id_wdata),
    .od_rdata(od_rdata), .od_ack(od_ack),
    .imem_ready(imem_ready),
    .owrite_req(owrite_req), .owrite_address(owrite_address), .owrite_data(owrite_data),
    .iwrite_ack(iwrite_ack),
    .oread_req(oread_req), .oread_address(oread_address),
    .iread_data(iread_data), .iread_ack(iread_ack)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Request lines as the arbiter saw them at the most recent clock edge.
  logic snap_i = 1'b0;
  logic snap_d = 1'b0;
  always @(posedge iclk) begin
    snap_i = ii_req;
    snap_d = id_req;
  end

  // Controller model plus reference checker
  bit           ctl_mid_ready = 0;
  bit           ctl_bad_ack = 0;
  bit           busy = 0;
  bit           cur_d = 0;
  bit           cur_rd = 0;
  bit           resp_pend = 0;
  bit           last_served_d = 0;
  bit           exp_d;
  int           cnt = 0;
  logic [127:0] m_i_data = '0;
  logic [127:0] m_d_data = '0;
  logic [127:0] rd_val = '0;
  int           grant_log[$];

  initial begin
    imem_ready = 1'b1;
    iwrite_ack = 1'b0;
    iread_ack  = 1'b0;
    iread_data = '0;
    forever begin
      @(negedge iclk);
      if (ireset) begin
        busy = 0; resp_pend = 0; last_served_d = 0;
        m_i_data = '0; m_d_data = '0;
        imem_ready = 1'b1; iwrite_ack = 1'b0; iread_ack = 1'b0;
        chk("rst_owrite_req", owrite_req, 0);
        chk("rst_oread_req", oread_req, 0);
        chk("rst_oi_ack", oi_ack, 0);
        chk("rst_od_ack", od_ack, 0);
        chk("rst_owrite_address", owrite_address, 0);
        chk("rst_oread_address", oread_address, 0);
        chk("rst_owrite_data", owrite_data, 0);
        chk("rst_oi_data", oi_data, 0);
        chk("rst_od_rdata", od_rdata, 0);
        continue;
      end
      // A completion signalled last cycle must show as a single ack now.
      if (resp_pend && cur_rd) begin
        if (cur_d) m_d_data = rd_val;
        else       m_i_data = rd_val;
      end
      chk("oi_ack", oi_ack, resp_pend && !cur_d);
      chk("od_ack", od_ack, resp_pend && cur_d);
      chk("oi_data", oi_data, m_i_data);
      chk("od_rdata", od_rdata, m_d_data);
      chk("req_exclusive", owrite_req & oread_req, 0);
      resp_pend = 0;
      iwrite_ack = 1'b0;
      iread_ack  = 1'b0;
      if (!busy) begin
        if (owrite_req || oread_req) begin
          if (snap_i && snap_d) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_d = !last_served_d;
`else
            exp_d = 1'b1;
`endif
          end else begin
            exp_d = snap_d;
          end
          chk("grant_any_req", snap_i | snap_d, 1);
          chk("grant_write", owrite_req, exp_d && id_we);
          chk("grant_read", oread_req, !(exp_d && id_we));
          chk("grant_addr", owrite_req ? owrite_address : oread_address,
              exp_d ? id_address : ii_address);
          if (owrite_req) chk("grant_wdata", owrite_data, id_wdata);
          grant_log.push_back(int'(owrite_req | oread_address[21]));
          cur_d = exp_d;
          cur_rd = oread_req;
          last_served_d = exp_d;
          busy = 1;
          imem_ready = 1'b0;
          cnt = $urandom_range(5, 2);
        end
      end else begin
        chk("req_low_while_busy", owrite_req | oread_req, 0);
        if (cnt > 0) begin
          cnt--;
          // Mimic the controller's read data phase raising ready early.
          imem_ready = ctl_mid_ready && (cnt <= 1);
          if (ctl_bad_ack && cnt == 1) begin
            if (cur_rd) begin
              iwrite_ack = 1'b1;
            end else begin
              iread_data = rand128();
              iread_ack  = 1'b1;
            end
          end
        end else begin
          if (cur_rd) begin
            rd_val = rand128();
            iread_data = rd_val;
            iread_ack = 1'b1;
          end else begin
            iwrite_ack = 1'b1;
          end
          resp_pend = 1;
          busy = 0;
          imem_ready = 1'b1;
        end
      end
    end
  end

  // Client model: drop on ack, optionally raise a fresh request.
  // I addresses keep bit 21 low and D addresses keep it high so grants can be told apart.
  task automatic client_step(input int p_raise);
    @(negedge iclk);
    if (oi_ack) begin
      ii_req = 1'b0;
    end else if (!ii_req && $urandom_range(99) < p_raise) begin
      ii_req = 1'b1;
      ii_address = 22'($urandom) & 22'h1FFFFF;
    end
    if (od_ack) begin
      id_req = 1'b0;
    end else if (!id_req && $urandom_range(99) < p_raise) begin
      id_req = 1'b1;
      id_we = 1'($urandom);
      id_address = 22'($urandom) | 22'h200000;
      id_wdata = rand128();
    end
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((ii_req || id_req) && k < budget) begin
      client_step(0);
      k++;
    end
    chk("drain_complete", ii_req | id_req, 0);
  endtask

  task automatic pulse_reset();
    @(negedge iclk);
    #1;
    ireset = 1'b1;
    ii_req = 1'b0;
    id_req = 1'b0;
    @(negedge iclk);
    @(negedge iclk);
    #1;
    ireset = 1'b0;
  endtask

  typedef struct {
    logic         i_req;
    logic         d_req;
    logic         d_we;
    logic [21:0]  i_addr;
    logic [21:0]  d_addr;
    logic [127:0] d_wdata;
    int           n_iss;
    logic [1:0]   e_wr;
    logic [1:0]   e_rd;
    logic [1:0][21:0] e_addr;
  } row_t;

  function automatic row_t mk_row(logic ir, logic dr, logic dwe, logic [21:0] ia,
                                  logic [21:0] da, logic [127:0] wd, int n,
                                  logic wr0, logic rd0, logic [21:0] a0,
                                  logic wr1, logic rd1, logic [21:0] a1);
    row_t r;
    r.i_req = ir; r.d_req = dr; r.d_we = dwe;
    r.i_addr = ia; r.d_addr = da; r.d_wdata = wd; r.n_iss = n;
    r.e_wr = {wr1, wr0}; r.e_rd = {rd1, rd0}; r.e_addr = {a1, a0};
    return r;
  endfunction

  row_t rows[6];
  int   n_seen;
  int   k_ack;
  int   k_iss;
  int   hk;

  initial begin
    rows[0] = mk_row(0, 1, 1, 22'h0, 22'h00ABC, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF,
                     1, 1, 0, 22'h00ABC, 0, 0, 22'h0);
    rows[1] = mk_row(1, 0, 0, 22'h12345, 22'h0, 128'h0,
                     1, 0, 1, 22'h12345, 0, 0, 22'h0);
    rows[2] = mk_row(0, 1, 0, 22'h0, 22'h3FFFFF, 128'h0,
                     1, 0, 1, 22'h3FFFFF, 0, 0, 22'h0);
    rows[3] = mk_row(1, 0, 0, 22'h000000, 22'h0, 128'h0,
                     1, 0, 1, 22'h000000, 0, 0, 22'h0);
    rows[4] = mk_row(1, 1, 0, 22'h00111, 22'h2AAAA, 128'h0,
                     2, 0, 1, 22'h2AAAA, 0, 1, 22'h00111);
    rows[5] = mk_row(1, 1, 1, 22'h0F0F0, 22'h15555, 128'h5555AAAA_00FF00FF_12345678_9ABCDEF0,
                     2, 1, 0, 22'h15555, 0, 1, 22'h0F0F0);

    repeat (3) @(negedge iclk);
    #1;
    ireset = 1'b0;

    // Table-driven single and paired transactions
    for (int r = 0; r < 6; r++) begin
      @(negedge iclk);
      ii_req = rows[r].i_req; ii_address = rows[r].i_addr;
      id_req = rows[r].d_req; id_we = rows[r].d_we;
      id_address = rows[r].d_addr; id_wdata = rows[r].d_wdata;
      n_seen = 0; k_ack = -1; k_iss = -1;
      for (int k = 0; k < 80 && (ii_req || id_req); k++) begin
        @(negedge iclk);
        if (owrite_req || oread_req) begin
          if (n_seen < 2) begin
            chk("row_owrite_req", owrite_req, rows[r].e_wr[n_seen]);
            chk("row_oread_req", oread_req, rows[r].e_rd[n_seen]);
            chk("row_addr", owrite_req ? owrite_address : oread_address,
                rows[r].e_addr[n_seen]);
          end
          if (n_seen == 1) k_iss = k;
          n_seen++;
        end
        if ((oi_ack || od_ack) && k_ack < 0) k_ack = k;
        if (oi_ack) ii_req = 1'b0;
        if (od_ack) id_req = 1'b0;
      end
      chk("row_issue_count", n_seen, rows[r].n_iss);
      chk("row_complete", ii_req | id_req, 0);
      if (rows[r].n_iss == 2) chk("row_second_issue_gap", k_iss - k_ack, 2);
    end

    // Mismatched acks must be ignored
    ctl_bad_ack = 1;
    @(negedge iclk);
    id_req = 1'b1; id_we = 1'b1; id_address = 22'h0BEEF; id_wdata = rand128();
    drain(60);
    @(negedge iclk);
    ii_req = 1'b1; ii_address = 22'h00777;
    drain(60);
    ctl_bad_ack = 0;

    // Controller raises ready during its read data phase
    ctl_mid_ready = 1;
    @(negedge iclk);
    ii_req = 1'b1; ii_address = 22'h01234;
    drain(60);
    @(negedge iclk);
    id_req = 1'b1; id_we = 1'b0; id_address = 22'h2F00D;
    drain(60);
    ctl_mid_ready = 0;

    // Reset while waiting for the controller, then a normal transaction
    @(negedge iclk);
    id_req = 1'b1; id_we = 1'b0; id_address = 22'h3ABCD;
    hk = 0;
    while (!oread_req && hk < 20) begin
      @(negedge iclk);
      hk++;
    end
    chk("reset_case_issued", oread_req, 1);
    @(negedge iclk);
    pulse_reset();
    @(negedge iclk);
    id_req = 1'b1; id_we = 1'b1; id_address = 22'h00042; id_wdata = rand128();
    drain(60);

    // Both ports requesting back to back from a fresh reset
    pulse_reset();
    grant_log.delete();
    hk = 0;
    while (grant_log.size() < 4 && hk < 200) begin
      client_step(100);
      hk++;
    end
    drain(100);
    chk("hammer_grants", grant_log.size() >= 4, 1);
    if (grant_log.size() >= 4) begin
      for (int g = 0; g < 4; g++) begin
`ifdef ARB_ROUND_ROBIN_EN
        chk("hammer_order", grant_log[g], (g % 2 == 0) ? 1 : 0);
`else
        chk("hammer_order", grant_log[g], 1);
`endif
      end
    end

    // Randomised traffic
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) begin
        ctl_mid_ready = 1'($urandom);
        ctl_bad_ack = 1'($urandom);
      end
      client_step(25);
    end
    drain(200);
    repeat (3) @(negedge iclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
